// File: rtl/imm_rot_encoder.sv
// Rotated-immediate encoder: searches one rotation per cycle for imm8/rot with ROR(imm8, 2*rot) == value.
// Optional macro IMM_ENC_NEG_EN also searches ~value in parallel and flags such hits on out_neg.
module imm_rot_encoder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_value,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_found,
  output logic [7:0]            out_imm8,
  output logic [3:0]            out_rot,
  output logic                  out_neg
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                state_q, next_state;
  logic [DATA_WIDTH-1:0] value_q;
  logic [3:0]            rot_q;
  logic                  found_q;
  logic [7:0]            imm8_q;
  logic [3:0]            rot_res_q;

  logic                  accept, step, take_hit, take_miss;
  logic                  hit_p, hit_n;
  logic [DATA_WIDTH-1:0] cand_p, cand_n;

  // Rotate left via a doubled word so a zero shift needs no special case.
  function automatic logic [DATA_WIDTH-1:0] rol(input logic [DATA_WIDTH-1:0] v,
                                                input logic [4:0] sh);
    logic [2*DATA_WIDTH-1:0] d;
    d = {v, v} << sh;
    return d[2*DATA_WIDTH-1:DATA_WIDTH];
  endfunction

  assign cand_p = rol(value_q, {rot_q, 1'b0});
  assign hit_p  = (cand_p[DATA_WIDTH-1:8] == '0);

`ifdef IMM_ENC_NEG_EN
  logic neg_q;

  assign cand_n  = rol(~value_q, {rot_q, 1'b0});
  assign hit_n   = (cand_n[DATA_WIDTH-1:8] == '0);
  assign out_neg = neg_q;
`else
  assign cand_n  = '0;
  assign hit_n   = 1'b0;
  assign out_neg = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      value_q   <= '0;
      rot_q     <= '0;
      found_q   <= 1'b0;
      imm8_q    <= '0;
      rot_res_q <= '0;
`ifdef IMM_ENC_NEG_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q <= next_state;
      if (accept) begin
        value_q <= in_value;
        rot_q   <= '0;
      end
      if (step) rot_q <= rot_q + 4'd1;
      if (take_hit) begin
        // Non-inverted hit wins when both operands match in the same rotation.
        found_q   <= 1'b1;
        imm8_q    <= hit_p ? cand_p[7:0] : cand_n[7:0];
        rot_res_q <= rot_q;
`ifdef IMM_ENC_NEG_EN
        neg_q     <= ~hit_p;
`endif
      end
      if (take_miss) begin
        found_q   <= 1'b0;
        imm8_q    <= '0;
        rot_res_q <= '0;
`ifdef IMM_ENC_NEG_EN
        neg_q     <= 1'b0;
`endif
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    take_hit   = 1'b0;
    take_miss  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          next_state = SEARCH;
        end
      end
      SEARCH: begin
        if (hit_p || hit_n) begin
          take_hit   = 1'b1;
          next_state = DONE;
        end else if (rot_q == 4'd15) begin
          take_miss  = 1'b1;
          next_state = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign out_found = found_q;
  assign out_imm8  = imm8_q;
  assign out_rot   = rot_res_q;

endmodule
